// File: rtl/mmul_pkg.sv
// Shared types and constants for the word-serial modular-multiply sequencer:
// FSM state encoding, control-bus field map and datapath mux codes.
package mmul_pkg;

  localparam int DEF_WORDS = 16;
  localparam int DEF_MAXIT = 256;
  localparam int CTRL_W    = 28;
  localparam int ITER_W    = 9;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LD_A,
    S_LD_B,
    S_LD_P,
    S_CHK,
    S_ADD,
    S_RED_C,
    S_DBL,
    S_RED_B,
    S_SHF,
    S_DONE
  } state_t;

  // Control bus bit positions; bits 25..27 are reserved and always zero.
  localparam int REGA_WE   = 0;
  localparam int REGA_SEL  = 1;
  localparam int REGB_WE   = 2;
  localparam int REGB_CYC  = 3;
  localparam int REGB_LS   = 4;
  localparam int REGC_WE   = 5;
  localparam int REGC_CYC  = 6;
  localparam int REGC_LS   = 7;
  localparam int REGD_WE   = 8;
  localparam int REGD_CYC  = 9;
  localparam int REGD_LS   = 10;
  localparam int REGP_WE   = 11;
  localparam int REGP_CYC  = 12;
  localparam int MUX0_LO   = 13;
  localparam int MUX1_LO   = 15;
  localparam int MUX3_SEL  = 17;
  localparam int ADD_SUB   = 18;
  localparam int CARRY_SEL = 19;
  localparam int DFF1_WE   = 20;
  localparam int C_FLAG_WE = 21;
  localparam int B_FLAG_WE = 22;
  localparam int MMUL_EN   = 23;
  localparam int SET_RDY   = 24;

  localparam logic [1:0] MUX0_C = 2'd0;
  localparam logic [1:0] MUX0_D = 2'd1;
  localparam logic [1:0] MUX0_B = 2'd2;

  localparam logic [1:0] MUX1_C = 2'd0;
  localparam logic [1:0] MUX1_D = 2'd1;
  localparam logic [1:0] MUX1_B = 2'd2;
  localparam logic [1:0] MUX1_P = 2'd3;

  function automatic state_t load_next(input state_t s);
    case (s)
      S_LD_A:  return S_LD_B;
      S_LD_B:  return S_LD_P;
      default: return S_CHK;
    endcase
  endfunction

  function automatic state_t loop_next(input state_t s);
    case (s)
      S_ADD:   return S_RED_C;
      S_RED_C: return S_DBL;
      S_DBL:   return S_RED_B;
      default: return S_SHF;
    endcase
  endfunction

  function automatic logic is_load(input state_t s);
    return (s == S_LD_A) || (s == S_LD_B) || (s == S_LD_P);
  endfunction

endpackage

// File: rtl/mmul_ctrl_if.sv
// Host/datapath-facing bundle of the sequencer: start, load handshake,
// A status inputs and the packed control bus with progress outputs.
interface mmul_ctrl_if;

  logic                         start;
  logic                         din_vld;
  logic                         din_rdy;
  logic                         a_nz;
  logic                         a0;
  logic [mmul_pkg::CTRL_W-1:0]  ctrl;
  logic                         busy;
  logic [mmul_pkg::ITER_W-1:0]  iter_cnt;

  modport master (
    output start, din_vld, a_nz, a0,
    input  din_rdy, ctrl, busy, iter_cnt
  );

  modport slave (
    input  start, din_vld, a_nz, a0,
    output din_rdy, ctrl, busy, iter_cnt
  );

endinterface

// File: rtl/mmul_ctrl_dec.sv
// Control-bus decoder: Moore decode of {state, wcnt}; din_vld only gates the
// register write enables while loading operands.
module mmul_ctrl_dec
  import mmul_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  state_t              state,
  input  logic [WCNT_W-1:0]   wcnt,
  input  logic                din_vld,
  output logic [CTRL_W-1:0]   ctrl
);

  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WORDS - 1);

  logic w_first;
  logic w_last;

  assign w_first = (wcnt == '0);
  assign w_last  = (wcnt == WLAST);

  always_comb begin
    ctrl = '0;
    case (state)
      S_CLR: ctrl[MMUL_EN] = 1'b1;
      S_LD_A: begin
        ctrl[REGA_WE]  = din_vld;
        ctrl[REGA_SEL] = 1'b0;
      end
      S_LD_B: begin
        ctrl[REGB_WE]  = din_vld;
        ctrl[MUX3_SEL] = 1'b0;
      end
      S_LD_P: ctrl[REGP_WE] = din_vld;
      // Word loops: operands rotate, destination shifts in the sum word.
      S_ADD: begin
        ctrl[REGC_CYC]       = 1'b1;
        ctrl[REGB_CYC]       = 1'b1;
        ctrl[REGD_WE]        = 1'b1;
        ctrl[REGD_LS]        = 1'b1;
        ctrl[MUX0_LO +: 2]   = MUX0_C;
        ctrl[MUX1_LO +: 2]   = MUX1_B;
        ctrl[ADD_SUB]        = 1'b0;
        ctrl[CARRY_SEL]      = w_first;
        ctrl[DFF1_WE]        = w_last;
      end
      S_RED_C: begin
        ctrl[REGD_CYC]       = 1'b1;
        ctrl[REGP_CYC]       = 1'b1;
        ctrl[REGC_WE]        = 1'b1;
        ctrl[REGC_LS]        = 1'b1;
        ctrl[MUX0_LO +: 2]   = MUX0_D;
        ctrl[MUX1_LO +: 2]   = MUX1_P;
        ctrl[ADD_SUB]        = 1'b1;
        ctrl[CARRY_SEL]      = w_first;
        ctrl[C_FLAG_WE]      = w_last;
      end
      S_DBL: begin
        ctrl[REGB_CYC]       = 1'b1;
        ctrl[REGD_WE]        = 1'b1;
        ctrl[REGD_LS]        = 1'b1;
        ctrl[MUX0_LO +: 2]   = MUX0_B;
        ctrl[MUX1_LO +: 2]   = MUX1_B;
        ctrl[ADD_SUB]        = 1'b0;
        ctrl[CARRY_SEL]      = w_first;
        ctrl[DFF1_WE]        = w_last;
      end
      S_RED_B: begin
        ctrl[REGD_CYC]       = 1'b1;
        ctrl[REGP_CYC]       = 1'b1;
        ctrl[REGB_WE]        = 1'b1;
        ctrl[REGB_LS]        = 1'b1;
        ctrl[MUX3_SEL]       = 1'b1;
        ctrl[MUX0_LO +: 2]   = MUX0_D;
        ctrl[MUX1_LO +: 2]   = MUX1_P;
        ctrl[ADD_SUB]        = 1'b1;
        ctrl[CARRY_SEL]      = w_first;
        ctrl[B_FLAG_WE]      = w_last;
      end
      S_SHF: begin
        ctrl[REGA_WE]  = 1'b1;
        ctrl[REGA_SEL] = 1'b1;
      end
      S_DONE: ctrl[SET_RDY] = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mmul_ctrl.sv
// Sequencer for the 256-bit word-serial modular multiplier: operand load,
// per-bit add/reduce/double/reduce/shift iterations and completion pulse.
module mmul_ctrl
  import mmul_pkg::*;
#(
  parameter int WORDS = DEF_WORDS,
  parameter int MAXIT = DEF_MAXIT
) (
  input  logic         clk,
  input  logic         rst,
  mmul_ctrl_if.slave   bus
);

  localparam int                WCNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WORDS - 1);
  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAXIT);

  state_t              state_reg;
  state_t              state_next;
  logic [WCNT_W-1:0]   wcnt_reg;
  logic [WCNT_W-1:0]   wcnt_next;
  logic [ITER_W-1:0]   iter_reg;
  logic [ITER_W-1:0]   iter_next;
  logic [ITER_W-1:0]   iter_inc;
  logic                w_last;

  assign w_last   = (wcnt_reg == WLAST);
  assign iter_inc = iter_reg + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      wcnt_reg  <= '0;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      iter_reg  <= iter_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    iter_next  = iter_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          state_next = S_CLR;
          iter_next  = '0;
        end
      end
      S_CLR: state_next = S_LD_A;
      // Loads advance only on a transfer, so din_vld gaps simply stall.
      S_LD_A, S_LD_B, S_LD_P: begin
        if (bus.din_vld) begin
          if (w_last) begin
            wcnt_next  = '0;
            state_next = load_next(state_reg);
          end else begin
            wcnt_next = wcnt_reg + WCNT_W'(1);
          end
        end
      end
      S_CHK: begin
        if (!bus.a_nz && !bus.a0) begin
          state_next = S_DONE;
        end else if (bus.a0) begin
          state_next = S_ADD;
        end else begin
          state_next = S_DBL;
        end
      end
      S_ADD, S_RED_C, S_DBL, S_RED_B: begin
        if (w_last) begin
          wcnt_next  = '0;
          state_next = loop_next(state_reg);
        end else begin
          wcnt_next = wcnt_reg + WCNT_W'(1);
        end
      end
      S_SHF: begin
        iter_next  = iter_inc;
        // Guard: stop after MAXIT iterations even if A is still non-zero.
        state_next = (iter_inc == ITER_MAX) ? S_DONE : S_CHK;
      end
      S_DONE: state_next = S_IDLE;
      default: begin
        state_next = S_IDLE;
        wcnt_next  = '0;
      end
    endcase
  end

  mmul_ctrl_dec #(
    .WORDS  (WORDS),
    .WCNT_W (WCNT_W)
  ) u_dec (
    .state   (state_reg),
    .wcnt    (wcnt_reg),
    .din_vld (bus.din_vld),
    .ctrl    (bus.ctrl)
  );

  assign bus.din_rdy  = is_load(state_reg);
  assign bus.busy     = (state_reg != S_IDLE);
  assign bus.iter_cnt = iter_reg;

endmodule
